// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci controller and its datapath.
// FIB_TIMEOUT_EN adds the ERR state used by the iteration watchdog.
package fib_pkg;

  localparam int unsigned FIB_W_DEFAULT       = 8;
  localparam int unsigned FIB_TIMEOUT_DEFAULT = 255;

  // Seeds the datapath loads while dp_load is high: reg1, reg2 and count.
  localparam int unsigned SEED_N1 = 0;
  localparam int unsigned SEED_N2 = 1;
  localparam int unsigned SEED_N3 = 0;

`ifdef FIB_TIMEOUT_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    HOLD = 3'd3
  } state_t;
`endif

endpackage

// File: rtl/fib_watchdog.sv
// Saturating iteration counter with a timeout flag; only used when the
// controller is built with FIB_TIMEOUT_EN.
module fib_watchdog #(
  parameter int W              = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         timeout
);

  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = (count >= LIMIT);

endmodule

// File: rtl/fib_control.sv
// Control FSM for an iterative Fibonacci datapath (IDLE/LOAD/ITER/HOLD).
// Define FIB_TIMEOUT_EN to add the iteration watchdog and the ERR state.
module fib_control
  import fib_pkg::*;
#(
  parameter int W              = FIB_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = FIB_TIMEOUT_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] n_in,
  output logic         busy,
  output logic [W-1:0] result,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         error,
  output logic         dp_load,
  output logic [W-1:0] dp_n,
  output logic         enable_reg1,
  output logic         enable_reg2,
  output logic         enable_regN,
  output logic         enable_count,
  input  logic         saida_do_comparador,
  input  logic [W-1:0] fib_saida,
  output logic [2:0]   dbg_state,
  output logic [W-1:0] dbg_iter
);

  // Handshake: result_valid is a register that stays high with result/error
  // frozen until a clock edge sees result_valid && result_ready; that edge
  // is the single transfer and drops result_valid.

  state_t       state;
  logic [1:0]   rst_sync;
  logic         rst_n_sync;
  logic         iter_go;
  logic [W-1:0] iter_count;

  // Assert asynchronously, release after two clean edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_sync = rst_sync[1];

`ifdef FIB_TIMEOUT_EN
  logic timeout;
  logic error_q;

  fib_watchdog #(.W(W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clock   (clock),
    .rst_n   (rst_n_sync),
    .clear   (state == LOAD),
    .inc     (iter_go),
    .count   (iter_count),
    .timeout (timeout)
  );

  assign iter_go = (state == ITER) && !saida_do_comparador && !timeout;
  assign error   = error_q;
`else
  assign iter_go = (state == ITER) && !saida_do_comparador;
  assign error   = 1'b0;

  always_ff @(posedge clock or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      iter_count <= '0;
    end else if (state == LOAD) begin
      iter_count <= '0;
    end else if (iter_go && (iter_count != {W{1'b1}})) begin
      iter_count <= iter_count + 1'b1;
    end
  end
`endif

  always_ff @(posedge clock or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state        <= IDLE;
      dp_n         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
`ifdef FIB_TIMEOUT_EN
      error_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dp_n  <= n_in;
            state <= LOAD;
          end
        end
        LOAD: state <= ITER;
        ITER: begin
          if (saida_do_comparador) begin
            result       <= fib_saida;
            result_valid <= 1'b1;
`ifdef FIB_TIMEOUT_EN
            error_q      <= 1'b0;
`endif
            state        <= HOLD;
          end
`ifdef FIB_TIMEOUT_EN
          else if (timeout) begin
            state <= ERR;
          end
`endif
        end
`ifdef FIB_TIMEOUT_EN
        ERR: begin
          result       <= '0;
          error_q      <= 1'b1;
          result_valid <= 1'b1;
          state        <= HOLD;
        end
`endif
        HOLD: begin
          // start is deliberately not looked at here; it is not queued.
          if (result_ready) begin
            result_valid <= 1'b0;
`ifdef FIB_TIMEOUT_EN
            error_q      <= 1'b0;
`endif
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Enables drop in the same cycle the comparator fires so the datapath freezes.
  assign dp_load      = (state == LOAD);
  assign enable_reg1  = dp_load || iter_go;
  assign enable_reg2  = dp_load || iter_go;
  assign enable_regN  = dp_load || iter_go;
  assign enable_count = dp_load || iter_go;
  assign busy         = (state != IDLE);
  assign dbg_state    = state;
  assign dbg_iter     = iter_count;

endmodule

// File: tb/tb_fib_control.sv
// Directed bench for fib_control with a behavioural Fibonacci datapath.
// Timeout expectations follow FIB_TIMEOUT_EN when it is defined.
module tb_fib_control;
  import fib_pkg::*;

  localparam int W  = 8;
  localparam int TO = 20;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] n_in = '0;
  logic         busy;
  logic [W-1:0] result;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic         error;
  logic         dp_load;
  logic [W-1:0] dp_n;
  logic         enable_reg1, enable_reg2, enable_regN, enable_count;
  logic         saida_do_comparador;
  logic [W-1:0] fib_saida;
  logic [2:0]   dbg_state;
  logic [W-1:0] dbg_iter;

  logic [W-1:0] dp_a = '0;
  logic [W-1:0] dp_b = '0;
  logic [W-1:0] dp_cnt = '0;
  logic         force_cmp0 = 1'b0;

  int total = 0;
  int bad   = 0;

  fib_control #(.W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .n_in                (n_in),
    .busy                (busy),
    .result              (result),
    .result_valid        (result_valid),
    .result_ready        (result_ready),
    .error               (error),
    .dp_load             (dp_load),
    .dp_n                (dp_n),
    .enable_reg1         (enable_reg1),
    .enable_reg2         (enable_reg2),
    .enable_regN         (enable_regN),
    .enable_count        (enable_count),
    .saida_do_comparador (saida_do_comparador),
    .fib_saida           (fib_saida),
    .dbg_state           (dbg_state),
    .dbg_iter            (dbg_iter)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Behavioural datapath: a=F(k), b=F(k+1), cnt=k after k iterations.
  always @(posedge clock) begin
    if (enable_reg1)  dp_a   <= dp_load ? W'(SEED_N1) : dp_b;
    if (enable_reg2)  dp_b   <= dp_load ? W'(SEED_N2) : dp_a + dp_b;
    if (enable_count) dp_cnt <= dp_load ? W'(SEED_N3) : dp_cnt + 1'b1;
  end
  assign fib_saida           = dp_a;
  assign saida_do_comparador = force_cmp0 ? 1'b0 : (dp_cnt >= dp_n);

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic kick(input logic [W-1:0] n);
    n_in  = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      step();
      if (result_valid) got = 1'b1;
    end
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b0;
    step(); step(); step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", result_valid); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", error); end
    total++; if ({dp_load, enable_reg1, enable_reg2, enable_regN, enable_count} !== 5'b0) begin
      bad++; $display("FAIL reset_enables got=%b want=00000",
                      {dp_load, enable_reg1, enable_reg2, enable_regN, enable_count});
    end
    total++; if (result !== '0 || dp_n !== '0 || dbg_iter !== '0) begin
      bad++; $display("FAIL reset_data result=%0d dp_n=%0d iter=%0d want=0", result, dp_n, dbg_iter);
    end
    reset = 1'b1;
    step(); step(); step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle busy=%b want=0", busy); end
  endtask

  task automatic test_fib10();
    bit got;
    result_ready = 1'b1;
    kick(8'd10);
    total++; if ({dp_load, enable_reg1, enable_reg2, enable_regN, enable_count} !== 5'b11111) begin
      bad++; $display("FAIL load_cycle got=%b want=11111",
                      {dp_load, enable_reg1, enable_reg2, enable_regN, enable_count});
    end
    total++; if (busy !== 1'b1 || dp_n !== 8'd10) begin
      bad++; $display("FAIL load_busy_dpn busy=%b dp_n=%0d want busy=1 dp_n=10", busy, dp_n);
    end
    step();
    total++; if (dp_load !== 1'b0 || enable_count !== 1'b1) begin
      bad++; $display("FAIL iter_enables dp_load=%b en_count=%b want 0/1", dp_load, enable_count);
    end
    wait_valid(40, got);
    total++; if (!got) begin bad++; $display("FAIL fib10_no_valid got=0 want=1"); end
    total++; if (result !== 8'd55) begin bad++; $display("FAIL fib10_result got=%0d want=55", result); end
    total++; if (dbg_iter !== 8'd10) begin bad++; $display("FAIL fib10_iters got=%0d want=10", dbg_iter); end
    step();
    total++; if (result_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL fib10_done valid=%b busy=%b want 0/0", result_valid, busy);
    end
  endtask

  task automatic test_hold();
    bit got;
    result_ready = 1'b0;
    kick(8'd1);
    wait_valid(20, got);
    total++; if (!got) begin bad++; $display("FAIL hold_no_valid got=0 want=1"); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (result !== 8'd1 || result_valid !== 1'b1 || busy !== 1'b1) begin
        bad++; $display("FAIL hold_stable cyc=%0d result=%0d valid=%b want 1/1", i, result, result_valid);
      end
      step();
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    total++; if (result_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL hold_transfer valid=%b busy=%b want 0/0", result_valid, busy);
    end
  endtask

  task automatic test_start_ignored();
    bit got;
    int valids;
    result_ready = 1'b0;
    kick(8'd7);
    n_in = 8'd3;
    got  = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      start = ~start;
      step();
      if (result_valid) got = 1'b1;
    end
    total++; if (!got || result !== 8'd13 || dp_n !== 8'd7) begin
      bad++; $display("FAIL fib7_result got=%0d dp_n=%0d want 13/7", result, dp_n);
    end
    start = 1'b1;
    result_ready = 1'b1;
    step();
    start = 1'b0;
    result_ready = 1'b0;
    total++; if (busy !== 1'b0 || result_valid !== 1'b0) begin
      bad++; $display("FAIL start_in_hold busy=%b valid=%b want 0/0", busy, result_valid);
    end
    valids = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (busy || result_valid) valids++;
    end
    total++; if (valids !== 0) begin bad++; $display("FAIL no_second_run busy_cycles=%0d want=0", valids); end
  endtask

  task automatic test_back_to_back();
    bit got;
    result_ready = 1'b1;
    kick(8'd0);
    wait_valid(10, got);
    total++; if (!got || result !== 8'd0 || dbg_iter !== 8'd0) begin
      bad++; $display("FAIL fib0 got=%0d iters=%0d want 0/0", result, dbg_iter);
    end
    step();
    kick(8'd13);
    wait_valid(40, got);
    total++; if (!got || result !== 8'd233) begin
      bad++; $display("FAIL fib13 got=%0d want=233", result);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int seen;
    result_ready = 1'b1;
    kick(8'd10);
    step(); step(); step();
    reset = 1'b0;
    #2;
    total++; if ({busy, result_valid, error, dp_load, enable_reg1, enable_reg2, enable_regN, enable_count} !== 8'b0
                 || dp_n !== '0 || result !== '0 || dbg_iter !== '0) begin
      bad++; $display("FAIL mid_reset_outputs busy=%b valid=%b en=%b dp_n=%0d want all 0",
                      busy, result_valid, enable_count, dp_n);
    end
    step(); step(); step();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (result_valid || busy) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_reset_no_valid cycles=%0d want=0", seen); end
  endtask

  task automatic test_timeout();
`ifdef FIB_TIMEOUT_EN
    bit got;
    force_cmp0   = 1'b1;
    result_ready = 1'b0;
    kick(8'd5);
    wait_valid(100, got);
    total++; if (!got || error !== 1'b1 || result !== 8'd0) begin
      bad++; $display("FAIL timeout_result valid=%b error=%b result=%0d want 1/1/0", got, error, result);
    end
    total++; if (dbg_iter !== 8'(TO)) begin
      bad++; $display("FAIL timeout_iters got=%0d want=%0d", dbg_iter, TO);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    force_cmp0   = 1'b0;
`else
    int idle;
    force_cmp0 = 1'b1;
    kick(8'd5);
    idle = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!busy || result_valid) idle++;
    end
    total++; if (idle !== 0 || error !== 1'b0) begin
      bad++; $display("FAIL no_timeout_busy idle_cycles=%0d error=%b want 0/0", idle, error);
    end
    total++; if (dbg_iter !== 8'hFF) begin
      bad++; $display("FAIL iter_saturate got=%0d want=255", dbg_iter);
    end
    force_cmp0 = 1'b0;
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step(); step(); step();
`endif
  endtask

  initial begin
    test_reset();
    test_fib10();
    test_hold();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fib_control.md
FIB_CONTROL -- requirements
Module: fib_control

Interface
REQ-001 Parameter W, default 8, datapath word width for N, count and result.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum ITER cycles before abort; used only with FIB_TIMEOUT_EN.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new computation; sampled only in IDLE.
REQ-006 n_in  input  W  term index N, latched on accepted start.
REQ-007 busy  output  1  high in LOAD, ITER and HOLD.
REQ-008 result  output  W  captured Fibonacci value.
REQ-009 result_valid  output  1  result (and error) stable and offered downstream.
REQ-010 result_ready  input  1  downstream accepts result.
REQ-011 error  output  1  result invalid because of timeout; constant 0 without FIB_TIMEOUT_EN.
REQ-012 dp_load  output  1  datapath seed-select (mux picks seeds n1/n2/n3).
REQ-013 dp_n  output  W  N driven to datapath, equal to latched n_in.
REQ-014 enable_reg1, enable_reg2, enable_regN, enable_count  output  1 each  datapath register enables.
REQ-015 saida_do_comparador  input  1  datapath termination flag (count has passed N).
REQ-016 fib_saida  input  W  datapath result register.

Function
REQ-017 FSM SHALL have states IDLE, LOAD, ITER, HOLD, plus ERR when FIB_TIMEOUT_EN is defined.
REQ-018 IDLE: all enables 0, dp_load 0; start=1 latches n_in into dp_n and moves to LOAD next edge.
REQ-019 LOAD: exactly one cycle; dp_load=1 and all four enables=1; next state ITER.
REQ-020 ITER: dp_load=0, all four enables=1 each cycle; iteration counter increments by 1, saturating at 2^W-1.
REQ-021 ITER: when saida_do_comparador=1 is sampled, enables SHALL be 0 in that same cycle (combinational gating), fib_saida captured into result at that edge, next state HOLD.
REQ-022 saida_do_comparador SHALL be ignored outside ITER, including its first LOAD-following cycle value only if it is already 1 (then capture immediately, zero iterations).
REQ-023 HOLD: result_valid=1, result/error held constant until result_ready=1; on result_ready=1 return to IDLE next edge.
REQ-024 result_valid SHALL be registered; result_valid and result_ready both high for one edge completes exactly one transfer.
REQ-025 start while busy=1 SHALL be ignored and not queued; start and result_ready high together in HOLD completes the transfer only.
REQ-026 n_in=0 SHALL run normally; termination is decided solely by saida_do_comparador.

Reset
REQ-027 reset low SHALL force IDLE immediately; busy, result_valid, error, dp_load, all enables 0; result and dp_n 0; iteration counter 0.
REQ-028 reset asserted mid-computation SHALL abort it with no result_valid pulse; release is synchronised through a two-flop deassertion stage.

Configuration
REQ-029 Macro FIB_TIMEOUT_EN: when defined, ITER reaching TIMEOUT_CYCLES iterations without saida_do_comparador SHALL deassert enables, go to ERR for one cycle, then HOLD with error=1 and result=0.
REQ-030 Without FIB_TIMEOUT_EN, ITER has no cycle limit, ERR and the watchdog logic are absent, and error is tied to 0.

Structure
REQ-031 Package fib_pkg SHALL hold the FSM state enum, W default, TIMEOUT_CYCLES default and the seed constants (n1=0, n2=1, n3=0) shared with the datapath.
REQ-032 One sub-module, fib_watchdog (iteration counter plus timeout compare), instantiated only under FIB_TIMEOUT_EN; without the macro the iteration counter stays inline.

Verification
REQ-033 Reset low for 3 cycles during ITER -> all outputs 0 at once, no result_valid afterwards.
REQ-034 With behavioural datapath, start, n_in=10, result_ready=1 -> result=55, result_valid high one cycle, busy back to 0.
REQ-035 n_in=1, result_ready held 0 for 5 cycles -> result=1 held stable with result_valid=1 throughout, transfer on the 6th cycle.
REQ-036 start pulsed repeatedly during ITER of n_in=7 -> exactly one result (13), no second computation.
REQ-037 FIB_TIMEOUT_EN, TIMEOUT_CYCLES=20, saida_do_comparador forced 0 -> error=1, result=0 after 20 iterations; without macro, busy stays 1 indefinitely.
